// File: rtl/cob_timing_rx_pkg.sv
// rtl/cob_timing_rx_pkg.sv - shared word types, FSM states and message record for the COB timing receiver
package cob_timing_rx_pkg;

  localparam logic [1:0] WT_IDLE   = 2'b00;
  localparam logic [1:0] WT_OPCODE = 2'b01;
  localparam logic [1:0] WT_HEADER = 2'b10;
  localparam logic [1:0] WT_DATA   = 2'b11;

  localparam int unsigned MAX_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [3:0]  mtype;
    logic [3:0]  len;
    logic [63:0] data;
  } cob_msg_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cob_msg_fifo.sv
// rtl/cob_msg_fifo.sv - message FIFO with synchronous write/pop, full/empty flags and occupancy count
module cob_msg_fifo
  import cob_timing_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  cob_msg_t      i_wdata,
  input  logic          i_pop,
  output cob_msg_t      o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  cob_msg_t    r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_wr;
  logic        w_do_pop;

  assign o_count  = r_wr_ptr - r_rd_ptr;
  assign o_empty  = (o_count == '0);
  assign o_full   = (o_count == (AW+1)'(DEPTH));
  assign w_do_pop = i_pop && !o_empty;
  // A pop frees the slot this same edge, so a full FIFO still accepts the write.
  assign w_do_wr  = i_wr && (!o_full || w_do_pop);
  assign o_rdata  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/cob_timing_rx.sv
// rtl/cob_timing_rx.sv - timing word decoder, message assembly FSM, checksum and error counters
module cob_timing_rx
  import cob_timing_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        distClk,
  input  logic        distClkRst,
  input  logic [9:0]  rxData,
  input  logic        rxDataEn,
  output logic        rxReady,
  output logic        opcodeValid,
  output logic [7:0]  opcode,
  output logic        msgValid,
  input  logic        msgReady,
  output logic [3:0]  msgType,
  output logic [3:0]  msgLen,
  output logic [63:0] msgData,
  output logic [15:0] chkErrCnt,
  output logic [15:0] frameErrCnt,
  output logic [15:0] ovflCnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  rx_state_t   r_state, w_state_n;
  logic [3:0]  r_type, w_type_n;
  logic [3:0]  r_len, w_len_n;
  logic [3:0]  r_cnt, w_cnt_n;
  logic [7:0]  r_chk, w_chk_n;
  logic [63:0] r_data, w_data_n;
  logic [15:0] r_tmo, w_tmo_n;
  logic        w_commit_n, w_frm_inc, w_chk_inc;

  logic        r_commit;
  cob_msg_t    r_commit_msg;
  logic        r_opcode_valid;
  logic [7:0]  r_opcode;
  logic        r_run;
  logic [15:0] r_chk_err, r_frm_err, r_ovfl;

  logic [1:0]  w_wtype;
  logic [7:0]  w_byte;
  logic        w_active;
  logic        w_hdr_ok;
  logic        w_pop;
  logic        w_full, w_empty;
  logic [CW-1:0] w_count;
  cob_msg_t    w_rdata;

  assign w_wtype  = rxData[9:8];
  assign w_byte   = rxData[7:0];
  assign w_active = rxDataEn && (w_wtype != WT_IDLE);
  assign w_hdr_ok = (w_byte[3:0] != 4'd0) && (w_byte[3:0] <= 4'(MAX_LEN));

  always_ff @(posedge distClk) begin
    if (distClkRst) begin
      r_state <= ST_IDLE;
      r_type  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_chk   <= '0;
      r_data  <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_n;
      r_type  <= w_type_n;
      r_len   <= w_len_n;
      r_cnt   <= w_cnt_n;
      r_chk   <= w_chk_n;
      r_data  <= w_data_n;
      r_tmo   <= w_tmo_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_type_n   = r_type;
    w_len_n    = r_len;
    w_cnt_n    = r_cnt;
    w_chk_n    = r_chk;
    w_data_n   = r_data;
    w_tmo_n    = r_tmo;
    w_commit_n = 1'b0;
    w_frm_inc  = 1'b0;
    w_chk_inc  = 1'b0;

    // Any enabled non-idle word, opcodes included, keeps a message alive.
    if (w_active) begin
      w_tmo_n = '0;
    end else if (r_state != ST_IDLE) begin
      if (r_tmo == TMO_LAST) begin
        w_state_n = ST_IDLE;
        w_frm_inc = 1'b1;
        w_tmo_n   = '0;
      end else begin
        w_tmo_n = r_tmo + 16'd1;
      end
    end

    if (rxDataEn) begin
      unique case (w_wtype)
        WT_HEADER: begin
          // One frame error per word even when an abort meets a bad header.
          if (r_state != ST_IDLE) w_frm_inc = 1'b1;
          if (w_hdr_ok) begin
            w_state_n = ST_PAYLOAD;
            w_type_n  = w_byte[7:4];
            w_len_n   = w_byte[3:0];
            w_chk_n   = w_byte;
            w_cnt_n   = '0;
            w_data_n  = '0;
          end else begin
            w_state_n = ST_IDLE;
            w_frm_inc = 1'b1;
          end
        end
        WT_DATA: begin
          unique case (r_state)
            ST_IDLE: w_frm_inc = 1'b1;
            ST_PAYLOAD: begin
              w_data_n[{r_cnt[2:0], 3'b000} +: 8] = w_byte;
              w_chk_n = r_chk ^ w_byte;
              w_cnt_n = r_cnt + 4'd1;
              if (r_cnt + 4'd1 == r_len) w_state_n = ST_CHECK;
            end
            ST_CHECK: begin
              if (w_byte == r_chk) w_commit_n = 1'b1;
              else                 w_chk_inc  = 1'b1;
              w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge distClk) begin
    if (distClkRst) begin
      r_commit       <= 1'b0;
      r_commit_msg   <= '0;
      r_opcode_valid <= 1'b0;
      r_opcode       <= '0;
      r_run          <= 1'b0;
      r_chk_err      <= '0;
      r_frm_err      <= '0;
      r_ovfl         <= '0;
    end else begin
      r_run          <= 1'b1;
      r_commit       <= w_commit_n;
      if (w_commit_n) r_commit_msg <= '{mtype: r_type, len: r_len, data: r_data};
      r_opcode_valid <= rxDataEn && (w_wtype == WT_OPCODE);
      if (rxDataEn && (w_wtype == WT_OPCODE)) r_opcode <= w_byte;
      if (w_chk_inc) r_chk_err <= sat_inc(r_chk_err);
      if (w_frm_inc) r_frm_err <= sat_inc(r_frm_err);
      if (r_commit && w_full && !w_pop) r_ovfl <= sat_inc(r_ovfl);
    end
  end

  cob_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (distClk),
    .i_rst   (distClkRst),
    .i_wr    (r_commit),
    .i_wdata (r_commit_msg),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign msgValid    = !w_empty;
  assign w_pop       = msgValid && msgReady;
  assign msgType     = msgValid ? w_rdata.mtype : 4'd0;
  assign msgLen      = msgValid ? w_rdata.len   : 4'd0;
  assign msgData     = msgValid ? w_rdata.data  : 64'd0;
  assign rxReady     = r_run && (w_count <= CW'(FIFO_DEPTH - 2));
  assign opcodeValid = r_opcode_valid;
  assign opcode      = r_opcode;
  assign chkErrCnt   = r_chk_err;
  assign frameErrCnt = r_frm_err;
  assign ovflCnt     = r_ovfl;

endmodule

// File: tb/tb_cob_timing_rx.sv
// tb/tb_cob_timing_rx.sv - scoreboard bench for the COB timing receiver
module tb_cob_timing_rx;

  logic        distClk = 1'b0;
  logic        distClkRst = 1'b1;
  logic [9:0]  rxData = '0;
  logic        rxDataEn = 1'b0;
  logic        msgReady = 1'b0;
  logic        rxReady, opcodeValid, msgValid;
  logic [7:0]  opcode;
  logic [3:0]  msgType, msgLen;
  logic [63:0] msgData;
  logic [15:0] chkErrCnt, frameErrCnt, ovflCnt;

  int tests = 0;
  int fails = 0;
  logic [71:0] sb_q[$];

  cob_timing_rx #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .distClk     (distClk),
    .distClkRst  (distClkRst),
    .rxData      (rxData),
    .rxDataEn    (rxDataEn),
    .rxReady     (rxReady),
    .opcodeValid (opcodeValid),
    .opcode      (opcode),
    .msgValid    (msgValid),
    .msgReady    (msgReady),
    .msgType     (msgType),
    .msgLen      (msgLen),
    .msgData     (msgData),
    .chkErrCnt   (chkErrCnt),
    .frameErrCnt (frameErrCnt),
    .ovflCnt     (ovflCnt)
  );

  always #5 distClk = ~distClk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge distClk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] b);
    rxData   = {t, b};
    rxDataEn = 1'b1;
    @(posedge distClk);
    #1;
    rxDataEn = 1'b0;
    rxData   = '0;
  endtask

  task automatic send_msg(input logic [7:0] hdr, input logic [63:0] data,
                          input logic [7:0] chk, input bit expect_commit);
    if (expect_commit) sb_q.push_back({hdr, data});
    send(2'b10, hdr);
    for (int i = 0; i < int'(hdr[3:0]); i++) send(2'b11, data[8*i +: 8]);
    send(2'b11, chk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_msgValid"}, 72'(msgValid), 72'd0);
    check({tag, "_opcodeValid"}, 72'(opcodeValid), 72'd0);
    check({tag, "_opcode"}, 72'(opcode), 72'd0);
    check({tag, "_rxReady"}, 72'(rxReady), 72'd0);
    check({tag, "_msgData"}, {msgType, msgLen, msgData}, 72'd0);
    check({tag, "_counters"}, 72'({chkErrCnt, frameErrCnt, ovflCnt}), 72'd0);
  endtask

  always @(negedge distClk) begin
    if (msgValid && msgReady) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_msg: got %0h required no message", {msgType, msgLen, msgData});
      end else begin
        logic [71:0] exp;
        exp = sb_q.pop_front();
        check("msg_type", 72'(msgType), 72'(exp[71:68]));
        check("msg_len", 72'(msgLen), 72'(exp[67:64]));
        check("msg_data", 72'(msgData), 72'(exp[63:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr, b;
    int waited;

    idle(3);
    check_all_zero("reset");
    distClkRst = 1'b0;
    idle(1);
    check("rxReady_after_reset", 72'(rxReady), 72'd1);
    msgReady = 1'b1;

    // Basic message and its latency
    sb_q.push_back({8'h32, 64'h2211});
    send(2'b10, 8'h32);
    send(2'b11, 8'h11);
    send(2'b11, 8'h22);
    send(2'b11, 8'h01);
    check("latency_cycle1", 72'(msgValid), 72'd0);
    idle(1);
    check("latency_cycle2", 72'(msgValid), 72'd1);
    idle(3);

    // Checksum mismatch
    send_msg(8'h32, 64'h2211, 8'h00, 1'b0);
    idle(3);
    check("chkErrCnt_1", 72'(chkErrCnt), 72'd1);
    check("no_msg_on_chkerr", 72'(msgValid), 72'd0);

    // Opcode mid-payload
    sb_q.push_back({8'h32, 64'h2211});
    send(2'b10, 8'h32);
    send(2'b11, 8'h11);
    send(2'b01, 8'h5A);
    check("opcode_strobe", 72'(opcodeValid), 72'd1);
    check("opcode_value", 72'(opcode), 72'h5A);
    idle(1);
    check("opcode_single_cycle", 72'(opcodeValid), 72'd0);
    check("opcode_held", 72'(opcode), 72'h5A);
    send(2'b11, 8'h22);
    send(2'b11, 8'h01);
    idle(3);

    // Timeout boundary, then bad headers and a stray data word in IDLE
    send(2'b10, 8'h32);
    send(2'b11, 8'h11);
    idle(254);
    check("frame_before_timeout", 72'(frameErrCnt), 72'd0);
    idle(1);
    check("frame_at_timeout", 72'(frameErrCnt), 72'd1);
    send(2'b10, 8'h09);
    check("frame_len9", 72'(frameErrCnt), 72'd2);
    send(2'b10, 8'h00);
    check("frame_len0", 72'(frameErrCnt), 72'd3);
    send(2'b11, 8'h55);
    check("frame_data_in_idle", 72'(frameErrCnt), 72'd4);

    // Maximum length payload
    send_msg(8'h78, 64'h0807060504030201, 8'h70, 1'b1);
    idle(3);

    // Header arriving mid-payload restarts the message
    send(2'b10, 8'h32);
    send(2'b11, 8'h11);
    send_msg(8'h21, 64'h44, 8'h65, 1'b1);
    idle(3);
    check("frame_restart", 72'(frameErrCnt), 72'd5);
    check("chkErrCnt_stable", 72'(chkErrCnt), 72'd1);

    // Backpressure, rxReady threshold and overflow
    msgReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      hdr = {4'(i), 4'h1};
      b   = 8'hA0 + 8'(i);
      send_msg(hdr, 64'(b), hdr ^ b, i <= 4);
      idle(1);
      check($sformatf("rxReady_after_msg%0d", i), 72'(rxReady), 72'(i <= 2));
    end
    check("ovflCnt_1", 72'(ovflCnt), 72'd1);
    msgReady = 1'b1;
    waited = 0;
    while (sb_q.size() != 0 && waited < 40) begin
      idle(1);
      waited++;
    end
    idle(1);
    check("drain_done", 72'(sb_q.size()), 72'd0);
    check("drain_msgValid", 72'(msgValid), 72'd0);
    check("drain_rxReady", 72'(rxReady), 72'd1);

    // Reset mid-message
    send(2'b10, 8'h32);
    send(2'b11, 8'h11);
    distClkRst = 1'b1;
    idle(1);
    check_all_zero("midreset");
    distClkRst = 1'b0;
    send_msg(8'h32, 64'h2211, 8'h01, 1'b1);
    idle(4);
    check("post_reset_sb_empty", 72'(sb_q.size()), 72'd0);
    check("post_reset_frame", 72'(frameErrCnt), 72'd0);
    check("post_reset_chk", 72'(chkErrCnt), 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
